// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter: FSM state codes,
// slot-select encoding and the priority pick helper.
package mem_arb_pkg;

    localparam int DEFAULT_TIMEOUT = 255;

    typedef logic [0:0] state_t;
    localparam state_t IDLE  = 1'b0;
    localparam state_t ISSUE = 1'b1;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_W    = 2'd1,
        SEL_D    = 2'd2,
        SEL_I    = 2'd3
    } sel_t;

    localparam logic [3:0] READ_STRB = 4'hF;

    // Writes go first so a read of the same address in one round sees new data.
    function automatic sel_t pick_slot(input logic w, input logic d, input logic i);
        sel_t s;
        s = SEL_NONE;
        if (w) begin
            s = SEL_W;
        end else if (d) begin
            s = SEL_D;
        end else if (i) begin
            s = SEL_I;
        end
        return s;
    endfunction

endpackage

// File: rtl/mem_arb_timeout.sv
// Bus watchdog: counts cycles a request waits for acknowledge and flags
// expiry once TIMEOUT_CYCLES is reached. Used only with MEM_ARB_TIMEOUT_EN.
module mem_arb_timeout
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic incr,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    assign expire = incr && (count == CW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (incr) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises the core's instruction-read, data-read and data-write channels
// onto one request/acknowledge bus. Optional watchdog: MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic        CLK,
    input  logic        RST,

    input  logic        INST_RDEN,
    input  logic [31:0] INST_RIADDR,
    output logic [31:0] INST_ROADDR,
    output logic        INST_RVALID,
    output logic [31:0] INST_RDATA,

    input  logic        DATA_RDEN,
    input  logic [31:0] DATA_RIADDR,
    output logic [31:0] DATA_ROADDR,
    output logic        DATA_RVALID,
    output logic [31:0] DATA_RDATA,

    input  logic        DATA_WREN,
    input  logic [3:0]  DATA_WSTRB,
    input  logic [31:0] DATA_WADDR,
    input  logic [31:0] DATA_WDATA,

    output logic        MEM_WAIT,

    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [3:0]  MEM_WSTRB,
    output logic [31:0] MEM_WDATA,
    input  logic        MEM_ACK,
    input  logic [31:0] MEM_RDATA,

    output logic        BUS_ERR
);

    state_t      state;
    sel_t        sel;
    sel_t        next_sel;

    logic        w_valid, d_valid, i_valid;
    logic        d_used, i_used;
    logic [31:0] w_addr, w_data, d_addr, i_addr;
    logic [3:0]  w_strb;

    logic        bus_req;
    logic        served;
    logic [31:0] rdata_eff;
    logic        any_en;
    logic        w_left, d_left, i_left;

    assign bus_req  = (state == ISSUE) && (sel != SEL_NONE);
    assign MEM_REQ  = bus_req;
    assign MEM_WAIT = (state == ISSUE);
    assign any_en   = INST_RDEN || DATA_RDEN || DATA_WREN;

    assign w_left   = w_valid && (sel != SEL_W);
    assign d_left   = d_valid && (sel != SEL_D);
    assign i_left   = i_valid && (sel != SEL_I);
    assign next_sel = pick_slot(w_left, d_left, i_left);

    // Bus fields come straight from the selected slot so they hold until acknowledge.
    always_comb begin
        MEM_WE    = 1'b0;
        MEM_ADDR  = '0;
        MEM_WSTRB = '0;
        MEM_WDATA = '0;
        case (sel)
            SEL_W: begin
                MEM_WE    = 1'b1;
                MEM_ADDR  = w_addr;
                MEM_WSTRB = w_strb;
                MEM_WDATA = w_data;
            end
            SEL_D: begin
                MEM_ADDR  = d_addr;
                MEM_WSTRB = READ_STRB;
            end
            SEL_I: begin
                MEM_ADDR  = i_addr;
                MEM_WSTRB = READ_STRB;
            end
            default: begin
                MEM_WE = 1'b0;
            end
        endcase
    end

`ifdef MEM_ARB_TIMEOUT_EN
    logic expired;
    logic wd_clear;
    logic timed_out;
    logic bus_err;

    assign wd_clear  = !bus_req || MEM_ACK || expired;
    assign timed_out = bus_req && expired && !MEM_ACK;
    assign served    = bus_req && (MEM_ACK || expired);
    assign rdata_eff = MEM_ACK ? MEM_RDATA : '0;
    assign BUS_ERR   = bus_err;

    mem_arb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (CLK),
        .rst_n  (RST),
        .clear  (wd_clear),
        .incr   (bus_req),
        .expire (expired)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bus_err <= 1'b0;
        end else if (timed_out) begin
            bus_err <= 1'b1;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign served    = bus_req && MEM_ACK;
    assign rdata_eff = MEM_RDATA;
    assign BUS_ERR   = 1'b0;
`endif

    // Round control: capture in IDLE, walk the slots in ISSUE, pulse responses at the end.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            sel         <= SEL_NONE;
            w_valid     <= 1'b0;
            d_valid     <= 1'b0;
            i_valid     <= 1'b0;
            d_used      <= 1'b0;
            i_used      <= 1'b0;
            INST_RVALID <= 1'b0;
            DATA_RVALID <= 1'b0;
        end else begin
            INST_RVALID <= 1'b0;
            DATA_RVALID <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_en) begin
                        state   <= ISSUE;
                        sel     <= pick_slot(DATA_WREN, DATA_RDEN, INST_RDEN);
                        w_valid <= DATA_WREN;
                        d_valid <= DATA_RDEN;
                        i_valid <= INST_RDEN;
                        d_used  <= DATA_RDEN;
                        i_used  <= INST_RDEN;
                    end
                end
                ISSUE: begin
                    if (served) begin
                        w_valid <= w_left;
                        d_valid <= d_left;
                        i_valid <= i_left;
                        sel     <= next_sel;
                        if (next_sel == SEL_NONE) begin
                            state       <= IDLE;
                            INST_RVALID <= i_used;
                            DATA_RVALID <= d_used;
                            i_used      <= 1'b0;
                            d_used      <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    sel   <= SEL_NONE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            w_addr <= '0;
            w_data <= '0;
            w_strb <= '0;
            d_addr <= '0;
            i_addr <= '0;
        end else if (state == IDLE) begin
            if (DATA_WREN) begin
                w_addr <= DATA_WADDR;
                w_data <= DATA_WDATA;
                w_strb <= DATA_WSTRB;
            end
            if (DATA_RDEN) begin
                d_addr <= DATA_RIADDR;
            end
            if (INST_RDEN) begin
                i_addr <= INST_RIADDR;
            end
        end
    end

    // Results land as each read completes; RVALID at round end marks them usable.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            INST_ROADDR <= '0;
            INST_RDATA  <= '0;
            DATA_ROADDR <= '0;
            DATA_RDATA  <= '0;
        end else if (served) begin
            if (sel == SEL_D) begin
                DATA_ROADDR <= d_addr;
                DATA_RDATA  <= rdata_eff;
            end
            if (sel == SEL_I) begin
                INST_ROADDR <= i_addr;
                INST_RDATA  <= rdata_eff;
            end
        end
    end

endmodule
